// File: rtl/bram_acc_scheduler_if.sv
// rtl/bram_acc_scheduler_if.sv - client request, accessor and status signals of the BRAM accumulate scheduler
interface bram_acc_scheduler_if #(
  parameter int CNT_BIT = 31,
  parameter int TO_BIT  = 16
);
  logic               req0_valid_i;
  logic [CNT_BIT-1:0] req0_count_i;
  logic               req0_ready_o;
  logic               req1_valid_i;
  logic [CNT_BIT-1:0] req1_count_i;
  logic               req1_ready_o;
  logic               acc_idle_i;
  logic               acc_done_i;
  logic               start_run_o;
  logic [CNT_BIT-1:0] run_count_o;
  logic               busy_o;
  logic               grant_id_o;
  logic               done0_o;
  logic               done1_o;
  logic               err_o;
  logic               clr_err_i;
  logic [TO_BIT-1:0]  last_cycles_o;

  modport slave (
    input  req0_valid_i, req0_count_i, req1_valid_i, req1_count_i,
    input  acc_idle_i, acc_done_i, clr_err_i,
    output req0_ready_o, req1_ready_o, start_run_o, run_count_o, busy_o,
    output grant_id_o, done0_o, done1_o, err_o, last_cycles_o
  );

  modport master (
    output req0_valid_i, req0_count_i, req1_valid_i, req1_count_i,
    output acc_idle_i, acc_done_i, clr_err_i,
    input  req0_ready_o, req1_ready_o, start_run_o, run_count_o, busy_o,
    input  grant_id_o, done0_o, done1_o, err_o, last_cycles_o
  );
endinterface

// File: rtl/bram_acc_scheduler.sv
// rtl/bram_acc_scheduler.sv - round-robin two-client job scheduler with watchdog for the BRAM accumulate accessor
module bram_acc_scheduler #(
  parameter int CNT_BIT     = 31,
  parameter int TO_BIT      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                 clk,
  input logic                 reset_n,
  bram_acc_scheduler_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, TOUT} state_t;

  state_t             state_q, state_d;
  logic               rr_ptr_q;
  logic               grant_id_q;
  logic [CNT_BIT-1:0] run_count_q;
  logic [TO_BIT-1:0]  wd_q;
  logic [TO_BIT-1:0]  last_cycles_q;
  logic               err_q;

  logic               any_valid;
  logic               winner;
  logic               grant;
  logic               wd_expired;
  logic [CNT_BIT-1:0] win_count;

  assign any_valid  = bus.req0_valid_i || bus.req1_valid_i;
  assign winner     = (bus.req0_valid_i && bus.req1_valid_i) ? rr_ptr_q : bus.req1_valid_i;
  assign win_count  = winner ? bus.req1_count_i : bus.req0_count_i;
  // ready is combinational, so it is also gated by reset to keep every output low while held in reset
  assign grant      = reset_n && (state_q == IDLE) && bus.acc_idle_i && any_valid;
  assign wd_expired = (wd_q == TO_BIT'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.req0_ready_o = 1'b0;
    bus.req1_ready_o = 1'b0;
    bus.start_run_o  = 1'b0;
    bus.busy_o       = 1'b1;
    bus.done0_o      = 1'b0;
    bus.done1_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.busy_o = 1'b0;
        if (grant) begin
          bus.req0_ready_o = !winner;
          bus.req1_ready_o = winner;
          state_d          = (win_count != '0) ? START : RESP;
        end
      end
      START: begin
        bus.start_run_o = 1'b1;
        state_d         = WAIT;
      end
      WAIT: begin
        // a done seen on the last watchdog cycle still counts as a normal completion
        if (bus.acc_done_i) begin
          state_d = RESP;
        end else if (wd_expired) begin
          state_d = TOUT;
        end
      end
      RESP, TOUT: begin
        bus.done0_o = !grant_id_q;
        bus.done1_o = grant_id_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q      <= 1'b0;
      grant_id_q    <= 1'b0;
      run_count_q   <= '0;
      wd_q          <= '0;
      last_cycles_q <= '0;
      err_q         <= 1'b0;
    end else begin
      if (grant) begin
        run_count_q <= win_count;
        grant_id_q  <= winner;
        if (win_count == '0) begin
          last_cycles_q <= '0;
        end
      end

      if (state_q == START) begin
        wd_q <= '0;
      end else if (state_q == WAIT) begin
        wd_q <= wd_q + 1'b1;
      end

      // timeout results are registered on the way into TOUT so they line up with the done pulse
      if (state_q == WAIT) begin
        if (bus.acc_done_i) begin
          last_cycles_q <= wd_q + 1'b1;
        end else if (wd_expired) begin
          last_cycles_q <= TO_BIT'(TIMEOUT_CYC);
        end
      end

      if (state_q == RESP) begin
        rr_ptr_q <= !grant_id_q;
      end

      if (bus.clr_err_i) begin
        err_q <= 1'b0;
      end else if ((state_q == WAIT) && !bus.acc_done_i && wd_expired) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.run_count_o   = run_count_q;
  assign bus.grant_id_o    = grant_id_q;
  assign bus.err_o         = err_q;
  assign bus.last_cycles_o = last_cycles_q;

endmodule

// File: tb/tb_bram_acc_scheduler.sv
// tb/tb_bram_acc_scheduler.sv - vector table, directed corner cases and randomized jobs against a job-level model
module tb_bram_acc_scheduler;

  localparam int CNT_BIT = 31;
  localparam int TO_BIT  = 16;
  localparam int TOUT    = 1024;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  logic model_ptr;

  bram_acc_scheduler_if #(.CNT_BIT(CNT_BIT), .TO_BIT(TO_BIT)) bus ();

  bram_acc_scheduler #(.CNT_BIT(CNT_BIT), .TO_BIT(TO_BIT), .TIMEOUT_CYC(TOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic               v0;
    logic               v1;
    logic [CNT_BIT-1:0] c0;
    logic [CNT_BIT-1:0] c1;
    int                 idle_wait;
    int                 dly;
    logic               exp_id;
    logic [TO_BIT-1:0]  exp_last;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic v0, input logic v1, input logic [CNT_BIT-1:0] c0,
                         input logic [CNT_BIT-1:0] c1, input int idle_wait, input int dly,
                         input logic exp_id, input logic [TO_BIT-1:0] exp_last, input string tag);
    logic [CNT_BIT-1:0] exp_cnt;
    logic [1:0]         exp_bits;
    exp_cnt  = exp_id ? c1 : c0;
    exp_bits = exp_id ? 2'b10 : 2'b01;
    bus.req0_valid_i = v0;
    bus.req1_valid_i = v1;
    bus.req0_count_i = c0;
    bus.req1_count_i = c1;
    bus.acc_idle_i   = 1'b0;
    for (int i = 0; i < idle_wait; i++) begin
      @(negedge clk);
      check({tag, "/gated_ready"}, {bus.req1_ready_o, bus.req0_ready_o}, 2'b00);
      step();
    end
    bus.acc_idle_i = 1'b1;
    @(negedge clk);
    check({tag, "/ready"}, {bus.req1_ready_o, bus.req0_ready_o}, exp_bits);
    check({tag, "/idle_busy"}, bus.busy_o, 1'b0);
    step();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    bus.acc_idle_i   = 1'b0;
    @(negedge clk);
    check({tag, "/grant_id"}, bus.grant_id_o, exp_id);
    check({tag, "/run_count"}, bus.run_count_o, exp_cnt);
    if (exp_cnt != '0) begin
      check({tag, "/start"}, {bus.start_run_o, bus.done1_o, bus.done0_o, bus.busy_o}, 4'b1001);
      step();
      for (int i = 1; i <= dly; i++) begin
        bus.acc_done_i = (i == dly);
        @(negedge clk);
        check({tag, "/wait"}, {bus.start_run_o, bus.done1_o, bus.done0_o, bus.busy_o}, 4'b0001);
        step();
      end
      bus.acc_done_i = 1'b0;
      @(negedge clk);
    end
    check({tag, "/done"}, {bus.start_run_o, bus.done1_o, bus.done0_o, bus.busy_o}, {1'b0, exp_bits, 1'b1});
    check({tag, "/last_cycles"}, bus.last_cycles_o, exp_last);
    check({tag, "/err"}, bus.err_o, 1'b0);
    step();
    @(negedge clk);
    check({tag, "/back_idle"}, {bus.busy_o, bus.done1_o, bus.done0_o}, 3'b000);
    step();
  endtask

  task automatic run_timeout(input logic v0, input logic v1, input logic exp_id,
                             input logic clr, input logic exp_err, input string tag);
    logic [1:0] exp_bits;
    exp_bits = exp_id ? 2'b10 : 2'b01;
    bus.clr_err_i    = clr;
    bus.req0_valid_i = v0;
    bus.req1_valid_i = v1;
    bus.req0_count_i = 31'd5;
    bus.req1_count_i = 31'd9;
    bus.acc_idle_i   = 1'b1;
    @(negedge clk);
    check({tag, "/ready"}, {bus.req1_ready_o, bus.req0_ready_o}, exp_bits);
    step();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    @(negedge clk);
    check({tag, "/start"}, bus.start_run_o, 1'b1);
    step();
    repeat (TOUT - 1) step();
    @(negedge clk);
    check({tag, "/last_wait"}, {bus.done1_o, bus.done0_o, bus.busy_o}, 3'b001);
    step();
    @(negedge clk);
    check({tag, "/tout_done"}, {bus.done1_o, bus.done0_o}, exp_bits);
    check({tag, "/tout_last"}, bus.last_cycles_o, 16'd1024);
    check({tag, "/tout_err"}, bus.err_o, exp_err);
    step();
    @(negedge clk);
    check({tag, "/after_busy"}, {bus.busy_o, bus.done1_o, bus.done0_o}, 3'b000);
    check({tag, "/after_err"}, bus.err_o, exp_err);
    step();
    bus.clr_err_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/ctrl"}, {bus.req1_ready_o, bus.req0_ready_o, bus.start_run_o, bus.busy_o,
                           bus.grant_id_o, bus.done1_o, bus.done0_o, bus.err_o}, 8'h00);
    check({tag, "/run_count"}, bus.run_count_o, 0);
    check({tag, "/last_cycles"}, bus.last_cycles_o, 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 31'd4, 31'd6, 0, 5, 1'b0, 16'd5};
    tbl[1] = '{1'b0, 1'b1, 31'd0, 31'd6, 0, 3, 1'b1, 16'd3};
    tbl[2] = '{1'b1, 1'b0, 31'd8, 31'd0, 0, 12, 1'b0, 16'd12};
    tbl[3] = '{1'b0, 1'b1, 31'd3, 31'd0, 0, 1, 1'b1, 16'd0};
    tbl[4] = '{1'b1, 1'b0, 31'd3, 31'd0, 4, 1, 1'b0, 16'd1};
    tbl[5] = '{1'b1, 1'b1, 31'd5, 31'd7, 1, 2, 1'b1, 16'd2};
    tbl[6] = '{1'b1, 1'b1, 31'd0, 31'd9, 0, 4, 1'b0, 16'd0};
    tbl[7] = '{1'b0, 1'b1, 31'd1, 31'h7fffffff, 2, 1, 1'b1, 16'd1};
    tbl[8] = '{1'b1, 1'b1, 31'd1, 31'd2, 0, 1024, 1'b0, 16'd1024};

    reset_n          = 1'b0;
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    bus.req0_count_i = 31'd4;
    bus.req1_count_i = 31'd6;
    bus.acc_idle_i   = 1'b1;
    bus.acc_done_i   = 1'b0;
    bus.clr_err_i    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_job(tbl[i].v0, tbl[i].v1, tbl[i].c0, tbl[i].c1, tbl[i].idle_wait, tbl[i].dly,
              tbl[i].exp_id, tbl[i].exp_last, $sformatf("vec%0d", i));
    end

    run_timeout(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "tout_a");
    bus.clr_err_i = 1'b1;
    @(negedge clk);
    check("clr_sync", bus.err_o, 1'b1);
    step();
    bus.clr_err_i = 1'b0;
    @(negedge clk);
    check("clr_done", bus.err_o, 1'b0);
    step();
    run_timeout(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "tout_clr_prio");
    run_timeout(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "tout_c");

    bus.req1_valid_i = 1'b1;
    bus.req1_count_i = 31'd10;
    bus.acc_idle_i   = 1'b1;
    @(negedge clk);
    check("rst_mid/ready", bus.req1_ready_o, 1'b1);
    step();
    bus.req1_valid_i = 1'b0;
    repeat (4) step();
    check("rst_mid/busy_before", {bus.busy_o, bus.grant_id_o, bus.err_o}, 3'b111);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    step();
    step();
    reset_n = 1'b1;
    run_job(1'b1, 1'b0, 31'd8, 31'd0, 0, 12, 1'b0, 16'd12, "post_rst");
    model_ptr = 1'b1;

    for (int n = 0; n < 40; n++) begin
      logic               v0, v1, id;
      logic [CNT_BIT-1:0] c0, c1;
      int                 dly, iw;
      logic [TO_BIT-1:0]  exp_last;
      v0  = $urandom_range(0, 1);
      v1  = $urandom_range(0, 1);
      if (!v0 && !v1) v0 = 1'b1;
      c0  = ($urandom_range(0, 3) == 0) ? '0 : CNT_BIT'($urandom_range(1, 100000));
      c1  = ($urandom_range(0, 3) == 0) ? '0 : CNT_BIT'($urandom_range(1, 100000));
      dly = $urandom_range(1, 20);
      iw  = $urandom_range(0, 3);
      id  = (v0 && v1) ? model_ptr : v1;
      exp_last  = ((id ? c1 : c0) == '0) ? '0 : TO_BIT'(dly);
      model_ptr = !id;
      run_job(v0, v1, c0, c1, iw, dly, id, exp_last, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
